// File: rtl/icache_lined.sv
// Direct-mapped instruction cache with multi-word lines, critical-word forwarding,
// whole-cache flush and redirect-cancel of the forwarded word.
module icache_lined #(
   parameter int INDEX_BITS = 4,
   parameter int WORD_BITS  = 2
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic        fetch_valid,
   input  logic [31:0] fetch_pc,
   input  logic        redirect,
   input  logic        flush,
   output logic        hit,
   output logic [31:0] hit_inst,
   output logic        mem_ask,
   output logic [31:0] mem_addr,
   input  logic        mem_valid,
   input  logic [31:0] mem_inst
);

   localparam int LINES    = 1 << INDEX_BITS;
   localparam int WORDS    = 1 << WORD_BITS;
   localparam int LSB      = WORD_BITS + 2;
   localparam int TAG_BITS = 32 - INDEX_BITS - LSB;

   typedef enum logic {IDLE, REFILL} state_t;

   state_t                state_q;
   logic [LINES-1:0]      valid_q;
   logic [TAG_BITS-1:0]   tag_q  [LINES];
   logic [31:0]           data_q [LINES][WORDS];
   logic [INDEX_BITS-1:0] line_q;
   logic [WORD_BITS-1:0]  crit_q;
   logic [WORD_BITS-1:0]  count_q;
   logic                  drop_q;
   logic                  poison_q;

   logic [WORD_BITS-1:0]  pc_off;
   logic [INDEX_BITS-1:0] pc_idx;
   logic [TAG_BITS-1:0]   pc_tag;
   logic                  lookup_hit;
   logic                  start_refill;
   logic                  last_beat;
   logic                  unused_byte_bits;

   assign pc_off           = fetch_pc[LSB-1:2];
   assign pc_idx           = fetch_pc[INDEX_BITS+LSB-1:LSB];
   assign pc_tag           = fetch_pc[31:INDEX_BITS+LSB];
   assign unused_byte_bits = ^fetch_pc[1:0];
   assign lookup_hit       = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
   assign start_refill     = (state_q == IDLE) && !flush && fetch_valid && !lookup_hit;
   assign last_beat        = (count_q == WORD_BITS'(WORDS - 1));

   // Tag and data storage carry no reset; the valid bits alone qualify them.
   always_ff @(posedge clk_in) begin
      if (rdy_in) begin
         if (start_refill)
            tag_q[pc_idx] <= pc_tag;
         if (state_q == REFILL && mem_valid)
            data_q[line_q][count_q] <= mem_inst;
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q  <= IDLE;
         valid_q  <= '0;
         line_q   <= '0;
         crit_q   <= '0;
         count_q  <= '0;
         drop_q   <= 1'b0;
         poison_q <= 1'b0;
         hit      <= 1'b0;
         hit_inst <= '0;
         mem_ask  <= 1'b0;
         mem_addr <= '0;
      end else if (rdy_in) begin
         case (state_q)
            IDLE: begin
               hit <= 1'b0;
               if (flush) begin
                  valid_q <= '0;
               end else if (fetch_valid && lookup_hit) begin
                  hit      <= 1'b1;
                  hit_inst <= data_q[pc_idx][pc_off];
               end else if (start_refill) begin
                  valid_q[pc_idx] <= 1'b0;
                  line_q          <= pc_idx;
                  crit_q          <= pc_off;
                  count_q         <= '0;
                  mem_ask         <= 1'b1;
                  mem_addr        <= {fetch_pc[31:LSB], {LSB{1'b0}}};
                  state_q         <= REFILL;
               end
            end
            REFILL: begin
               hit <= 1'b0;
               if (redirect)
                  drop_q <= 1'b1;
               if (flush) begin
                  valid_q  <= '0;
                  poison_q <= 1'b1;
               end
               if (mem_valid) begin
                  count_q  <= count_q + 1'b1;
                  mem_addr <= mem_addr + 32'd4;
                  // Same-cycle redirect/flush also cancels the forward.
                  if (count_q == crit_q && !drop_q && !redirect && !flush) begin
                     hit      <= 1'b1;
                     hit_inst <= mem_inst;
                  end
                  if (last_beat) begin
                     mem_ask         <= 1'b0;
                     mem_addr        <= '0;
                     valid_q[line_q] <= !poison_q && !flush;
                     drop_q          <= 1'b0;
                     poison_q        <= 1'b0;
                     state_q         <= IDLE;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_icache_lined.sv
// Directed bench for icache_lined: refill, forwarding, redirect, flush, stall and reset.
module tb_icache_lined;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        rdy_in;
   logic        fetch_valid;
   logic [31:0] fetch_pc;
   logic        redirect;
   logic        flush;
   logic        hit;
   logic [31:0] hit_inst;
   logic        mem_ask;
   logic [31:0] mem_addr;
   logic        mem_valid;
   logic [31:0] mem_inst;

   int vectors     = 0;
   int miscompares = 0;

   icache_lined dut (
      .clk_in      (clk_in),
      .rst_in      (rst_in),
      .rdy_in      (rdy_in),
      .fetch_valid (fetch_valid),
      .fetch_pc    (fetch_pc),
      .redirect    (redirect),
      .flush       (flush),
      .hit         (hit),
      .hit_inst    (hit_inst),
      .mem_ask     (mem_ask),
      .mem_addr    (mem_addr),
      .mem_valid   (mem_valid),
      .mem_inst    (mem_inst)
   );

   always #5 clk_in = ~clk_in;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic beat(input logic [31:0] d);
      mem_valid = 1'b1;
      mem_inst  = d;
      tick();
      mem_valid = 1'b0;
   endtask

   initial begin
      rst_in = 1'b1; rdy_in = 1'b1; fetch_valid = 1'b0; fetch_pc = '0;
      redirect = 1'b0; flush = 1'b0; mem_valid = 1'b0; mem_inst = '0;
      tick(); tick();
      check("rst_hit", {31'b0, hit}, 32'd0);
      check("rst_hit_inst", hit_inst, 32'd0);
      check("rst_mem_ask", {31'b0, mem_ask}, 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      rst_in = 1'b0;

      // Miss on 0x1004, critical word is offset 1
      fetch_valid = 1'b1; fetch_pc = 32'h1004;
      tick();
      check("miss1_ask", {31'b0, mem_ask}, 32'd1);
      check("miss1_addr", mem_addr, 32'h1000);
      check("miss1_hit", {31'b0, hit}, 32'd0);
      beat(32'hA0);
      check("b0_hit", {31'b0, hit}, 32'd0);
      check("b0_addr", mem_addr, 32'h1004);
      beat(32'hA1);
      check("fwd_hit", {31'b0, hit}, 32'd1);
      check("fwd_inst", hit_inst, 32'hA1);
      beat(32'hA2);
      check("b2_hit", {31'b0, hit}, 32'd0);
      beat(32'hA3);
      check("b3_ask", {31'b0, mem_ask}, 32'd0);
      check("b3_addr", mem_addr, 32'd0);

      fetch_pc = 32'h100C;
      tick();
      check("hit_100c", {31'b0, hit}, 32'd1);
      check("hit_100c_inst", hit_inst, 32'hA3);
      check("hit_100c_ask", {31'b0, mem_ask}, 32'd0);
      fetch_valid = 1'b0;
      tick();
      check("idle_nofetch_hit", {31'b0, hit}, 32'd0);

      // Conflict miss on same index, different tag
      fetch_valid = 1'b1; fetch_pc = 32'h1104;
      tick();
      check("conf_ask", {31'b0, mem_ask}, 32'd1);
      check("conf_addr", mem_addr, 32'h1100);
      beat(32'hB0); beat(32'hB1);
      check("conf_fwd", hit_inst, 32'hB1);
      beat(32'hB2); beat(32'hB3);

      // Redirect before the critical (3rd) beat
      fetch_pc = 32'h2008;
      tick();
      check("redir_addr", mem_addr, 32'h2000);
      beat(32'hD0);
      check("redir_b0_hit", {31'b0, hit}, 32'd0);
      beat(32'hD1);
      check("redir_b1_hit", {31'b0, hit}, 32'd0);
      redirect = 1'b1;
      tick();
      redirect = 1'b0;
      check("redir_gap_hit", {31'b0, hit}, 32'd0);
      beat(32'hD2);
      check("redir_crit_hit", {31'b0, hit}, 32'd0);
      beat(32'hD3);
      check("redir_done_ask", {31'b0, mem_ask}, 32'd0);
      tick();
      check("redir_refetch_hit", {31'b0, hit}, 32'd1);
      check("redir_refetch_inst", hit_inst, 32'hD2);

      // Fill index 1 so the flush below has another valid line to clear
      fetch_pc = 32'h4010;
      tick();
      check("l1_addr", mem_addr, 32'h4010);
      beat(32'hC0);
      check("l1_fwd", hit_inst, 32'hC0);
      beat(32'hC1); beat(32'hC2); beat(32'hC3);
      fetch_pc = 32'h4014;
      tick();
      check("l1_hit", {31'b0, hit}, 32'd1);
      check("l1_hit_inst", hit_inst, 32'hC1);

      // Flush during refill of 0x3000
      fetch_pc = 32'h3000;
      tick();
      check("fl_addr", mem_addr, 32'h3000);
      beat(32'hE0);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      beat(32'hE1); beat(32'hE2);
      check("fl_still_ask", {31'b0, mem_ask}, 32'd1);
      beat(32'hE3);
      check("fl_done_ask", {31'b0, mem_ask}, 32'd0);
      tick();
      check("fl_remiss_hit", {31'b0, hit}, 32'd0);
      check("fl_remiss_ask", {31'b0, mem_ask}, 32'd1);
      check("fl_remiss_addr", mem_addr, 32'h3000);
      beat(32'hF0); beat(32'hF1); beat(32'hF2); beat(32'hF3);
      fetch_pc = 32'h4014;
      tick();
      check("fl_other_ask", {31'b0, mem_ask}, 32'd1);
      check("fl_other_addr", mem_addr, 32'h4010);
      beat(32'h60);
      redirect = 1'b1;
      beat(32'h61);
      redirect = 1'b0;
      check("samecyc_redir_hit", {31'b0, hit}, 32'd0);
      beat(32'h62); beat(32'h63);
      tick();
      check("samecyc_valid_hit", {31'b0, hit}, 32'd1);
      check("samecyc_valid_inst", hit_inst, 32'h61);

      // Flush in IDLE overrides a cached fetch
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("idle_fl_hit", {31'b0, hit}, 32'd0);
      check("idle_fl_ask", {31'b0, mem_ask}, 32'd0);
      tick();
      check("post_fl_ask", {31'b0, mem_ask}, 32'd1);
      check("post_fl_addr", mem_addr, 32'h4010);

      // Stall mid-refill, then reset
      beat(32'h70);
      rdy_in = 1'b0; mem_valid = 1'b1; mem_inst = 32'h71;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stall_addr", mem_addr, 32'h4014);
         check("stall_hit", {31'b0, hit}, 32'd0);
         check("stall_ask", {31'b0, mem_ask}, 32'd1);
      end
      rdy_in = 1'b1; mem_valid = 1'b0;
      rst_in = 1'b1;
      #1;
      check("async_rst_ask", {31'b0, mem_ask}, 32'd0);
      check("async_rst_addr", mem_addr, 32'd0);
      #2;
      rst_in = 1'b0;
      tick();
      check("post_rst_ask", {31'b0, mem_ask}, 32'd1);
      check("post_rst_addr", mem_addr, 32'h4010);
      check("post_rst_hit", {31'b0, hit}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
